rr_prefer_alloc: RTL

- Registered, pointer-based rotating-priority allocator for RANGE request slots, e.g. picking a free warp slot or CU for a CTA dispatch.
- Keeps its own priority pointer. The pointer can be reloaded externally or advanced round-robin after each grant.
- Tracks granted-but-unreleased slots in a busy mask, so a slot is not granted again until it is released.
- Presents the winner through a valid/ready output register. RANGE need not be a power of two.

---
 rtl/rr_prefer_alloc_if.sv | 27 ++
 rtl/rr_prefer_alloc.sv | 102 ++++++++++
 2 files changed

// File: rtl/rr_prefer_alloc_if.sv
// Request/grant bundle for rr_prefer_alloc.
// The allocator sits on the slave modport and the requester/consumer on the master modport.
interface rr_prefer_alloc_if #(
    parameter int RANGE    = 4,
    parameter int ID_WIDTH = 2
);
    logic [RANGE-1:0]    signal_i;
    logic [ID_WIDTH-1:0] prefer_i;
    logic                prefer_load_i;
    logic [RANGE-1:0]    release_i;
    logic                ready_i;
    logic                valid_o;
    logic [ID_WIDTH-1:0] id_o;
    logic [RANGE-1:0]    oh_o;
    logic [RANGE-1:0]    busy_o;
    logic [ID_WIDTH-1:0] ptr_o;

    modport master (
        output signal_i, prefer_i, prefer_load_i, release_i, ready_i,
        input  valid_o, id_o, oh_o, busy_o, ptr_o
    );

    modport slave (
        input  signal_i, prefer_i, prefer_load_i, release_i, ready_i,
        output valid_o, id_o, oh_o, busy_o, ptr_o
    );
endinterface

// File: rtl/rr_prefer_alloc.sv
// Registered rotating-priority allocator with a busy mask and a valid/ready grant register.
// RANGE may be any value >= 2; all index arithmetic wraps modulo RANGE.
module rr_prefer_alloc #(
    parameter int RANGE       = 4,
    parameter int ID_WIDTH    = 2,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit USE_BUSY    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    rr_prefer_alloc_if.slave bus
);

    logic                valid_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [RANGE-1:0]    oh_q;
    logic [RANGE-1:0]    busy_q;
    logic [ID_WIDTH-1:0] ptr_q;

    logic                hs;
    logic                load;
    logic [RANGE-1:0]    handoff;
    logic [RANGE-1:0]    elig;
    logic [ID_WIDTH-1:0] start;
    logic                win_found;
    logic [ID_WIDTH-1:0] win_id;
    logic [RANGE-1:0]    win_oh;
    logic [RANGE-1:0]    busy_next;
    logic [ID_WIDTH-1:0] ptr_next;
    int                  scan;

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
        return (v == ID_WIDTH'(RANGE - 1)) ? '0 : v + ID_WIDTH'(1);
    endfunction

    // ready_i only reaches the registers below; valid_o/id_o never see it combinationally.
    assign hs      = valid_q & bus.ready_i;
    assign load    = ~valid_q | bus.ready_i;
    assign handoff = oh_q & {RANGE{hs}};
    assign elig    = bus.signal_i & ~busy_q & ~handoff;
    assign start   = (hs && ROUND_ROBIN) ? wrap_inc(id_q) : ptr_q;

    // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = 0;
        for (int k = 0; k < RANGE; k++) begin
            scan = int'(start) + k;
            if (scan >= RANGE) scan = scan - RANGE;
            if (!win_found && elig[scan]) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(scan);
            end
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[win_id] = 1'b1;
    end

    // A handshake on a bit being released in the same cycle leaves it busy.
    assign busy_next = USE_BUSY ? ((busy_q & ~bus.release_i) | handoff) : '0;

    always_comb begin
        ptr_next = ptr_q;
        if (bus.prefer_load_i) begin
            ptr_next = ({1'b0, bus.prefer_i} < (ID_WIDTH + 1)'(RANGE)) ? bus.prefer_i : '0;
        end else if (hs && ROUND_ROBIN) begin
            ptr_next = wrap_inc(id_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            oh_q    <= '0;
            busy_q  <= '0;
            ptr_q   <= '0;
        end else begin
            busy_q <= busy_next;
            ptr_q  <= ptr_next;
            if (load) begin
                valid_q <= win_found;
                if (win_found) begin
                    id_q <= win_id;
                    oh_q <= win_oh;
                end
            end
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.id_o    = id_q;
    assign bus.oh_o    = oh_q;
    assign bus.busy_o  = busy_q;
    assign bus.ptr_o   = ptr_q;

endmodule
